// File: rtl/tune_player.sv
// Programmable multi-tune piezo sequencer: host-written note table, square-wave playback with busy/done/stop.
// Optional build macro TUNE_LOOP_EN makes a tune restart at note 0 when loop is high at its end.
module tune_player #(
  parameter int FAST_SIM  = 1,
  parameter int NUM_TUNES = 4,
  parameter int MAX_NOTES = 16,
  parameter int DUR_BASE  = 21,
  parameter int DUR_W     = 24,
  localparam int TW = $clog2(NUM_TUNES),
  localparam int NW = $clog2(MAX_NOTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [TW+NW-1:0] wr_addr,
  input  logic [18:0]   wr_data,
  input  logic          go,
  input  logic [TW-1:0] tune_sel,
  input  logic          stop,
  input  logic          loop,
  output logic          busy,
  output logic          done,
  output logic          piezo,
  output logic          piezo_n
);

  localparam int DEPTH = NUM_TUNES * MAX_NOTES;
  localparam logic [DUR_W-1:0] INC = (FAST_SIM != 0) ? DUR_W'(16) : DUR_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t          state;
  logic [TW-1:0]   tune;
  logic [NW-1:0]   idx;
  logic [DUR_W-1:0] dur_cnt;
  logic [15:0]     per;
  logic [15:0]     per_cnt;
  logic            note_last;
  logic [18:0]     note_mem [DEPTH];
  logic [18:0]     rd_data;

  function automatic logic [DUR_W-1:0] note_dur(input logic [1:0] sel);
    note_dur = DUR_W'(1) << DUR_BASE;
    case (sel)
      2'd1:    note_dur = DUR_W'(1) << (DUR_BASE + 1);
      2'd2:    note_dur = DUR_W'(1) << (DUR_BASE + 2);
      2'd3:    note_dur = (DUR_W'(1) << (DUR_BASE + 2)) | (DUR_W'(1) << (DUR_BASE + 1));
      default: note_dur = DUR_W'(1) << DUR_BASE;
    endcase
  endfunction

  // Table read runs every cycle; the FETCH address is valid in LOAD.
  always_ff @(posedge clk) begin
    if (wr_en) note_mem[wr_addr] <= wr_data;
    rd_data <= note_mem[{tune, idx}];
  end

`ifndef TUNE_LOOP_EN
  logic unused_loop;
  assign unused_loop = loop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tune      <= '0;
      idx       <= '0;
      dur_cnt   <= '0;
      per       <= '0;
      per_cnt   <= '0;
      note_last <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go && !stop) begin
              tune  <= tune_sel;
              idx   <= '0;
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            dur_cnt   <= note_dur(rd_data[17:16]);
            per       <= rd_data[15:0];
            note_last <= rd_data[18];
            per_cnt   <= '0;
            state     <= PLAY;
          end
          PLAY: begin
            per_cnt <= (per_cnt == per - 16'd1) ? 16'd0 : per_cnt + 16'd1;
            dur_cnt <= dur_cnt - INC;
            // The final PLAY cycle is the one whose decrement reaches zero.
            if (dur_cnt <= INC) begin
              if (note_last || idx == NW'(MAX_NOTES - 1)) begin
`ifdef TUNE_LOOP_EN
                if (loop) begin
                  idx   <= '0;
                  state <= FETCH;
                end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                end
`else
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
`endif
              end else begin
                idx   <= idx + NW'(1);
                state <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign piezo   = (state == PLAY) && (per != 16'd0) && (per_cnt >= (per >> 1));
  assign piezo_n = ~piezo;

endmodule

// File: tb/tb_tune_player.sv
// Bench for tune_player: directed and random tunes checked cycle by cycle against a per-note trace model.
module tb_tune_player;
  localparam int NT = 4;
  localparam int MN = 16;
  localparam int B  = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [18:0] wr_data = '0;
  logic        go = 1'b0;
  logic [1:0]  tune_sel = '0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        busy, done, piezo, piezo_n;

  int checks = 0;
  int errors = 0;
  logic [18:0] shadow [NT*MN];
  bit eb[$], ep[$], ed[$];

  tune_player #(.FAST_SIM(1), .NUM_TUNES(NT), .MAX_NOTES(MN), .DUR_BASE(B), .DUR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .tune_sel(tune_sel), .stop(stop), .loop(loop),
    .busy(busy), .done(done), .piezo(piezo), .piezo_n(piezo_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] ent(input bit last, input int sel, input int per);
    logic [1:0]  s = sel[1:0];
    logic [15:0] p = per[15:0];
    return {last, s, p};
  endfunction

  task automatic wr(input int addr, input logic [18:0] d);
    wr_en = 1'b1;
    wr_addr = addr[5:0];
    wr_data = d;
    step();
    wr_en = 1'b0;
    shadow[addr] = d;
  endtask

  function automatic void push(input bit b, input bit p, input bit d);
    eb.push_back(b);
    ep.push_back(p);
    ed.push_back(d);
  endfunction

  // Expected outputs for each cycle after go is taken, built note by note from the table image.
  function automatic void build(input int tune, input bit lp, input int cap);
    int idx = 0;
    int n = 0;
    bit ended = 0;
    eb.delete(); ep.delete(); ed.delete();
    while (!ended && n < cap) begin
      logic [18:0] e;
      int per, mult, d;
      e = shadow[tune*MN + idx];
      per = int'(e[15:0]);
      case (e[17:16])
        2'd0: mult = 1;
        2'd1: mult = 2;
        2'd2: mult = 4;
        default: mult = 6;
      endcase
      d = ((1 << B) * mult) / 16;
      push(1, 0, 0);
      push(1, 0, 0);
      for (int k = 0; k < d; k++)
        push(1, (per != 0) ? ((k % per) >= (per / 2)) : 1'b0, 0);
      n++;
      if (e[18] || idx == MN-1) begin
        if (lp) idx = 0;
        else ended = 1;
      end else idx++;
    end
    if (ended) begin
      push(0, 0, 1);
      push(0, 0, 0);
    end
  endfunction

  task automatic play(input string tag, input int tune, input bit disturb, output int busy_cnt);
    busy_cnt = 0;
    tune_sel = tune[1:0];
    go = 1'b1;
    for (int i = 0; i < eb.size(); i++) begin
      step();
      go = 1'b0;
      wr_en = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      chk({tag, "_busy"}, busy, eb[i]);
      chk({tag, "_piezo"}, piezo, ep[i]);
      chk({tag, "_piezo_n"}, piezo_n, !ep[i]);
      chk({tag, "_done"}, done, ed[i]);
      if (disturb && i == 3) begin
        go = 1'b1;
        tune_sel = tune_sel + 2'd1;
        wr_en = 1'b1;
        wr_addr = 6'(tune*MN + 1);
        wr_data = shadow[tune*MN + 1];
      end
    end
  endtask

  initial begin
    int bc;
    repeat (2) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_piezo", piezo, 1'b0);
    chk("rst_piezo_n", piezo_n, 1'b1);
    rst_n = 1'b1;
    step();

    // Directed tune 1: {8,sel1},{4,sel0,last}
    wr(1*MN + 0, ent(0, 1, 8));
    wr(1*MN + 1, ent(1, 0, 4));
    build(1, 0, 99);
    play("tune1", 1, 0, bc);
    chk("tune1_busy_len", bc, 2 + 8 + 2 + 4);

    // Rest note followed by a tone
    wr(2*MN + 0, ent(0, 0, 0));
    wr(2*MN + 1, ent(1, 1, 3));
    build(2, 0, 99);
    play("rest", 2, 0, bc);

    // Random tunes
    for (int r = 0; r < 6; r++) begin
      int t = $urandom_range(0, NT-1);
      int n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++)
        wr(t*MN + j, ent(j == n-1, $urandom_range(0, 3), $urandom_range(0, 12)));
      build(t, 0, 99);
      play("rand", t, 0, bc);
    end

    // Stop mid-note
    wr(1*MN + 0, ent(0, 1, 8));
    wr(1*MN + 1, ent(1, 0, 4));
    tune_sel = 2'd1;
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (7) step();
    chk("stop_pre_busy", busy, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", busy, 1'b0);
    chk("stop_piezo", piezo, 1'b0);
    chk("stop_done", done, 1'b0);
    step();
    chk("stop_done2", done, 1'b0);
    chk("stop_busy2", busy, 1'b0);

    // go together with stop in IDLE
    go = 1'b1;
    stop = 1'b1;
    step();
    go = 1'b0;
    stop = 1'b0;
    chk("gostop_busy", busy, 1'b0);
    step();
    chk("gostop_busy2", busy, 1'b0);
    chk("gostop_done", done, 1'b0);

    // go while busy is ignored; a write to the next entry is played
    shadow[1*MN + 1] = ent(1, 0, 2);
    build(1, 0, 99);
    play("gobusy", 1, 1, bc);

    // Full tune of MAX_NOTES entries without a last bit
    for (int j = 0; j < MN; j++)
      wr(3*MN + j, ent(0, 0, $urandom_range(0, 6)));
    loop = 1'b1;
`ifdef TUNE_LOOP_EN
    build(3, 1, MN + 2);
    play("loop", 3, 0, bc);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("loop_stop_busy", busy, 1'b0);
    chk("loop_stop_done", done, 1'b0);
`else
    build(3, 0, 99);
    play("wrap", 3, 0, bc);
`endif
    loop = 1'b0;

    // Reset mid-PLAY, then replay with the retained table
    tune_sel = 2'd1;
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_piezo", piezo, 1'b0);
    chk("midrst_piezo_n", piezo_n, 1'b1);
    chk("midrst_done", done, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    build(1, 0, 99);
    play("replay", 1, 0, bc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
